// File: rtl/servo_pwm_gen.sv
// Servo PWM output stage: fixed-period pulse whose width tracks an 8-bit duty code,
// with duty sampled once per period and a one-cycle period_start strobe.
//
// state | meaning
// IDLE  | stopped, pwm_out low, waiting for enable
// HIGH  | pulse portion of the period
// LOW   | remainder of the period after the pulse
module servo_pwm_gen #(
  parameter int PRESCALE     = 100,
  parameter int PERIOD_TICKS = 20000,
  parameter int MIN_TICKS    = 1000,
  parameter int STEP_TICKS   = 4,
  parameter int MAX_TICKS    = 2000,
  parameter int CW           = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] duty,
  output logic       pwm_out,
  output logic       period_start,
  output logic [7:0] duty_q
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CW-1:0]   pulse_ticks_q, pulse_ticks_d;
  logic [CW-1:0]   pulse_calc;
  logic [31:0]     pulse_full;
  logic [7:0]      duty_d;
  logic            pwm_d, strobe_d;
  logic            tick, period_end, latch;

  // Wide enough that 255*STEP cannot wrap before the saturation compare.
  assign pulse_full = 32'(MIN_TICKS) + 32'(duty) * 32'(STEP_TICKS);
  assign pulse_calc = (pulse_full > 32'(MAX_TICKS)) ? CW'(MAX_TICKS) : pulse_full[CW-1:0];

  assign tick       = (pre_cnt_q == PW'(PRESCALE - 1));
  assign period_end = tick && (tick_cnt_q == CW'(PERIOD_TICKS - 1));
  assign latch      = enable && ((state_q == IDLE) || ((state_q == LOW) && period_end));

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    tick_cnt_d    = tick_cnt_q;
    pulse_ticks_d = pulse_ticks_q;
    duty_d        = duty_q;
    pwm_d         = pwm_out;
    strobe_d      = 1'b0;

    case (state_q)
      IDLE: begin
        pre_cnt_d  = '0;
        tick_cnt_d = '0;
        pwm_d      = 1'b0;
      end
      HIGH: begin
        pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);
        if (tick) begin
          tick_cnt_d = tick_cnt_q + CW'(1);
          if (tick_cnt_q == pulse_ticks_q - CW'(1)) begin
            state_d = LOW;
            pwm_d   = 1'b0;
          end
        end
      end
      LOW: begin
        pwm_d     = 1'b0;
        pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);
        if (tick) tick_cnt_d = tick_cnt_q + CW'(1);
        if (period_end) begin
          state_d    = IDLE;
          pre_cnt_d  = '0;
          tick_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pwm_d   = 1'b0;
      end
    endcase

    // Period latch overrides the boundary handling above for back-to-back periods.
    if (latch) begin
      state_d       = HIGH;
      pre_cnt_d     = '0;
      tick_cnt_d    = '0;
      pulse_ticks_d = pulse_calc;
      duty_d        = duty;
      pwm_d         = 1'b1;
      strobe_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pre_cnt_q     <= '0;
      tick_cnt_q    <= '0;
      pulse_ticks_q <= '0;
      duty_q        <= '0;
      pwm_out       <= 1'b0;
      period_start  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      pulse_ticks_q <= pulse_ticks_d;
      duty_q        <= duty_d;
      pwm_out       <= pwm_d;
      period_start  <= strobe_d;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: period-level reference model checked every cycle,
// a table of duty/pulse-width vectors, and hand sequences for the corner cases.
module tb_servo_pwm_gen;

  localparam int PRE    = 2;
  localparam int PERIOD = 20;
  localparam int MINT   = 4;
  localparam int STEP   = 1;
  localparam int MAXT   = 12;
  localparam int PCLKS  = PERIOD * PRE;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] duty;
  logic       pwm_out;
  logic       period_start;
  logic [7:0] duty_q;

  servo_pwm_gen #(
    .PRESCALE(PRE), .PERIOD_TICKS(PERIOD), .MIN_TICKS(MINT),
    .STEP_TICKS(STEP), .MAX_TICKS(MAXT), .CW(5)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .duty(duty),
    .pwm_out(pwm_out), .period_start(period_start), .duty_q(duty_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: a period is a run of PCLKS cycles, high for the first width cycles.
  bit         m_run   = 1'b0;
  int         m_phase = 0;
  int         m_width = 0;
  logic [7:0] m_dq    = 8'd0;

  typedef struct {
    logic [7:0] duty;
    int         exp_high;
  } vec_t;

  vec_t vecs[7];

  function automatic int width_clks(input int d);
    int w;
    w = MINT + d * STEP;
    if (w > MAXT) w = MAXT;
    return w * PRE;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_start();
    m_run   = 1'b1;
    m_phase = 0;
    m_width = width_clks(int'(duty));
    m_dq    = duty;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) begin
      m_run = 1'b0; m_phase = 0; m_dq = 8'd0;
    end else if (!m_run) begin
      if (enable) model_start();
    end else begin
      m_phase++;
      if (m_phase == PCLKS) begin
        if (enable) model_start();
        else m_run = 1'b0;
      end
    end
    #1;
    check("model_pwm", int'(pwm_out), int'(m_run && (m_phase < m_width)));
    check("model_ps", int'(period_start), int'(m_run && (m_phase == 0)));
    check("model_dq", int'(duty_q), int'(m_dq));
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 200);
    check("wait_start", int'(period_start), 1);
  endtask

  // Called on a strobe cycle: measures one full period of pulse width and length.
  task automatic measure(input int exp_high, input int exp_dq);
    int high;
    high = 0;
    check("meas_dq", int'(duty_q), exp_dq);
    for (int i = 0; i < PCLKS; i++) begin
      if (pwm_out) high++;
      if (i > 0) check("meas_no_early_ps", int'(period_start), 0);
      step();
    end
    check("meas_high", high, exp_high);
    check("meas_period", int'(period_start), 1);
  endtask

  initial begin
    int high;
    vecs[0] = '{8'd0,   8};
    vecs[1] = '{8'd1,   10};
    vecs[2] = '{8'd5,   18};
    vecs[3] = '{8'd7,   22};
    vecs[4] = '{8'd8,   24};
    vecs[5] = '{8'd200, 24};
    vecs[6] = '{8'd255, 24};

    reset  = 1'b0;
    enable = 1'b1;
    duty   = 8'd77;

    // Reset held with enable high: everything stays 0.
    for (int i = 0; i < 3; i++) step();
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ps", int'(period_start), 0);
    check("rst_dq", int'(duty_q), 0);
    reset = 1'b1;
    step();
    check("rel_ps", int'(period_start), 1);
    check("rel_dq", int'(duty_q), 77);

    foreach (vecs[k]) begin
      duty = vecs[k].duty;
      wait_start();
      measure(vecs[k].exp_high, int'(vecs[k].duty));
    end

    // Duty change mid-period is deferred to the next latch.
    duty = 8'd5;
    wait_start();
    high = 0;
    for (int i = 0; i < PCLKS; i++) begin
      if (i == 5) duty = 8'd0;
      if (pwm_out) high++;
      step();
    end
    check("midchg_high", high, 18);
    check("midchg_ps", int'(period_start), 1);
    measure(8, 0);

    // Enable dropped mid-period: full pulse, period completes, then idle.
    duty = 8'd5;
    wait_start();
    high = 0;
    for (int i = 0; i < PCLKS; i++) begin
      if (i == 3) enable = 1'b0;
      if (pwm_out) high++;
      step();
    end
    check("dis_high", high, 18);
    check("dis_ps", int'(period_start), 0);
    check("dis_pwm", int'(pwm_out), 0);
    for (int i = 0; i < 20; i++) step();
    enable = 1'b1;
    step();
    check("reen_ps", int'(period_start), 1);
    check("reen_dq", int'(duty_q), 5);

    // Asynchronous reset between edges while the pulse is high.
    for (int i = 0; i < 3; i++) step();
    check("pre_async_pwm", int'(pwm_out), 1);
    #2;
    reset = 1'b0;
    #1;
    m_run = 1'b0; m_phase = 0; m_dq = 8'd0;
    check("async_pwm", int'(pwm_out), 0);
    check("async_dq", int'(duty_q), 0);
    step();
    step();
    reset = 1'b1;
    wait_start();
    measure(18, 5);

    // Random run: duty and enable wander, model checks every cycle.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if ($urandom_range(0, 24) == 0) duty = 8'($urandom_range(0, 255));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
